pipeline_hazard_ctrl: RTL

//  Sequences the 5-stage pipeline around the EX stage.

---
 rtl/pipeline_hazard_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Front-end sequencing around EX. It inserts a single bubble for a load-use pair,
// redirects and flushes on a taken branch in MEM, honours an external freeze,
// and keeps saturating counters of bubbles and redirects.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Freeze,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             IF_ID_UsesRt,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_WriteReg,
  input  logic             MEM_Branch,
  input  logic             MEM_Zero,
  output logic             PCSrc,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // state    | meaning
  // Run      | normal issue; load-use detection active
  // LuStall  | bubble sits in ID/EX; detection suppressed for one cycle
  typedef enum logic {
    Run     = 1'b0,
    LuStall = 1'b1
  } stateT;

  localparam logic [CNT_W-1:0] cntMax = '1;
  localparam logic [CNT_W-1:0] cntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  stateT state;
  logic  taken;
  logic  loadUse;
  logic  rsHit;
  logic  rtHit;

  assign taken   = MEM_Branch & MEM_Zero;
  assign rsHit   = (IF_ID_rs == ID_EX_WriteReg);
  assign rtHit   = IF_ID_UsesRt & (IF_ID_rt == ID_EX_WriteReg);
  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign loadUse = ID_EX_MemRead & (ID_EX_WriteReg != '0) & (rsHit | rtHit);

  // State and event counters; a freeze holds everything, a taken branch overrides any stall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= Run;
      StallCount <= '0;
      FlushCount <= '0;
    end else if (!Freeze) begin
      if (taken) begin
        state <= Run;
        if (FlushCount != cntMax) FlushCount <= FlushCount + cntOne;
      end else if ((state == Run) && loadUse) begin
        state <= LuStall;
        if (StallCount != cntMax) StallCount <= StallCount + cntOne;
      end else begin
        state <= Run;
      end
    end
  end

  // Control outputs decoded from state and inputs in priority order.
  always_comb begin
    PCSrc        = 1'b0;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    if (Reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (Freeze) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (taken) begin
      PCSrc        = 1'b1;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if ((state == Run) && loadUse) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

endmodule
